speaker_arbiter: RTL and testbench
==================================

# speaker_arbiter

Owns the single speaker output and shares it among the three mode sources: free-play piano, auto-play and learning. It debounces the mode switches, asks the outgoing source to stop, holds a silent guard interval and then grants the incoming source, so that mode changes never glitch the speaker. It sits between the mode datapaths and the speaker pin and replaces the direct combinational mode mux in the top level.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 2_000_000: cycles the decoded mode must stay stable before it is accepted (20 ms at 100 MHz).
- GUARD_CYCLES, 1_000_000: length of the silent gap between sources.
- ACK_TIMEOUT, 5_000_000: maximum wait for a stop acknowledge.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: reset. Asynchronous, active-low.
- mode_select, input, 3: raw mode switches, asynchronous to clk.
- src_speaker, input, 3: speaker bit from each source. bit0 = free, bit1 = auto, bit2 = learn.
- src_stop_ack, input, 3: per-source acknowledge that the source is quiesced. It is a level, indexed the same way as src_speaker.
- src_enable, output, 3: one-hot run enable to the sources.
- src_stop_req, output, 3: one-hot stop request.
- speaker, output, 1: registered speaker drive.
- current_mode, output, 2: mode currently granted. 0 = free, 1 = auto, 2 = learn.
- switching, output, 1: high whenever the FSM is not in ACTIVE.

## Operation
- **Input conditioning**
  - mode_select passes through a 2-FF synchronizer.
  - It is then decoded: 0 → free, 1 → auto, 2 → learn, any other value → free.
- **Debouncer**
  - Counts consecutive cycles in which the decoded value is unchanged. A change reloads the count to 0.
  - When the count reaches DEBOUNCE_CYCLES-1, target_mode takes the decoded value.
  - Reset value of target_mode is free.
- **FSM states:** ACTIVE, STOP_REQ, GUARD, GRANT.
  - **ACTIVE:** src_enable is one-hot at current_mode, and speaker follows src_speaker[current_mode]. If target_mode ≠ current_mode, go to STOP_REQ.
  - **STOP_REQ:** assert src_stop_req[current_mode] and keep src_enable asserted. speaker is forced to 0. On src_stop_ack[current_mode], or on timeout (see Configuration), go to GUARD.
  - **GUARD:** src_enable = 0 and src_stop_req = 0. speaker = 0. Count GUARD_CYCLES, then go to GRANT.
  - **GRANT:** current_mode takes the *current* target_mode, so a change made mid-switch wins. If that equals the old mode, the old source is simply re-granted. src_enable is set one-hot at the new mode. Go to ACTIVE.
- **Arithmetic:** all counters are $clog2(param)+1 bits wide, saturate, and are cleared on every state entry.
- **Reset values:** state ACTIVE, current_mode 0, src_enable 3'b001, src_stop_req 0, speaker 0, switching 0, all counters 0.
- **Reset asserted mid-switch:** everything returns to the reset values immediately (asynchronous). No stop handshake is performed.

## Timing
- The registered speaker output lags src_speaker by 1 cycle.
- A mode_select change reaches target_mode after 2 (sync) + DEBOUNCE_CYCLES cycles.
- The FSM enters STOP_REQ on the cycle after target_mode changes.
- **Ack path:** src_stop_ack sampled high in STOP_REQ moves the FSM to GUARD on the next edge. GUARD lasts exactly GUARD_CYCLES cycles. GRANT lasts 1 cycle.
- **Total source-change latency:** from ack to new speaker data it is GUARD_CYCLES + 2 cycles.
- An ack that is already high on entry to STOP_REQ is honoured on the first STOP_REQ cycle. STOP_REQ therefore lasts at least 1 cycle.
- switching rises with entry to STOP_REQ and falls with entry to ACTIVE.

## Configuration
- **SPEAKER_ARB_TIMEOUT_EN defined:** STOP_REQ leaves to GUARD after ACK_TIMEOUT cycles even if no ack arrives.
- **Not defined:** STOP_REQ waits for the ack indefinitely. The ACK_TIMEOUT parameter is still declared but ignored, and the timeout counter is not built.

## Structure
- **Shared package keyboard_pkg:**
  - mode constants MODE_FREE = 2'd0, MODE_AUTO = 2'd1, MODE_LEARN = 2'd2;
  - the arbiter state encoding;
  - the source index convention.
- **Sub-module mode_debouncer:** contains the synchronizer, decode and stability counter, and outputs target_mode. The FSM and speaker mux stay in speaker_arbiter.

## Test plan
Bench parameters: DEBOUNCE_CYCLES = 4, GUARD_CYCLES = 8, ACK_TIMEOUT = 16.
- **Reset:** release reset with mode_select = 0 → src_enable = 001, current_mode = 0, speaker = 0, then speaker tracks src_speaker[0] with 1-cycle lag.
- **Switch to auto:** mode_select 0→1 with src_stop_ack[0] returned 3 cycles after the request → src_stop_req = 001 for those cycles, then 8 cycles with speaker = 0 and src_enable = 000, then src_enable = 010, current_mode = 1, switching low.
- **Bounce:** mode_select toggles 0↔2 every 2 cycles for 20 cycles, then returns to 0 → FSM never leaves ACTIVE and switching stays 0.
- **Change during guard:** request learn, then set mode_select back to 0 during GUARD so it debounces before GRANT → GRANT re-grants free, src_enable = 001, current_mode = 0.
- **Timeout:** no ack given. With SPEAKER_ARB_TIMEOUT_EN, GUARD is entered after 16 cycles of STOP_REQ. Without it, the FSM stays in STOP_REQ for 100+ cycles.
- **Async reset:** assert reset in the middle of GUARD → all outputs return to reset values with no clock edge.

Source files
------------

// File: rtl/keyboard_pkg.sv
// Shared definitions for the keyboard mode sources and speaker arbiter:
// mode codes, source indices, arbiter state encoding and small helpers.
package keyboard_pkg;

  localparam logic [1:0] MODE_FREE  = 2'd0;
  localparam logic [1:0] MODE_AUTO  = 2'd1;
  localparam logic [1:0] MODE_LEARN = 2'd2;

  localparam int SRC_FREE  = 0;
  localparam int SRC_AUTO  = 1;
  localparam int SRC_LEARN = 2;
  localparam int NUM_SRC   = 3;

  typedef enum logic [1:0] {
    ST_ACTIVE   = 2'd0,
    ST_STOP_REQ = 2'd1,
    ST_GUARD    = 2'd2,
    ST_GRANT    = 2'd3
  } arb_state_t;

  function automatic logic [1:0] decode_mode(
    input logic [2:0] sel
  );
    logic [1:0] m;
    m = MODE_FREE;
    unique case (1'b1)
      (sel == 3'd1): m = MODE_AUTO;
      (sel == 3'd2): m = MODE_LEARN;
      default:       m = MODE_FREE;
    endcase
    return m;
  endfunction

  function automatic logic [NUM_SRC-1:0] mode_onehot(
    input logic [1:0] m
  );
    logic [NUM_SRC-1:0] oh;
    oh = '0;
    unique case (1'b1)
      (m == MODE_AUTO):  oh[SRC_AUTO]  = 1'b1;
      (m == MODE_LEARN): oh[SRC_LEARN] = 1'b1;
      default:           oh[SRC_FREE]  = 1'b1;
    endcase
    return oh;
  endfunction

  function automatic logic mode_bit(
    input logic [NUM_SRC-1:0] v,
    input logic [1:0]         m
  );
    logic b;
    b = 1'b0;
    unique case (1'b1)
      (m == MODE_AUTO):  b = v[SRC_AUTO];
      (m == MODE_LEARN): b = v[SRC_LEARN];
      default:           b = v[SRC_FREE];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mode_debouncer.sv
// Synchronizes and debounces the raw mode switches into target_mode.
// Ports: clk, reset (async active-low), mode_select[2:0], target_mode[1:0].
module mode_debouncer
  import keyboard_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] mode_select,
  output logic [1:0] target_mode
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [1:0]    dec;
  logic [1:0]    dec_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  assign dec = decode_mode(sync2);

  // Accept on the edge where the run length reaches
  // its last count, so target follows 2 + N cycles
  // after the switch moves.
  always_comb begin
    cnt_nxt = cnt;
    if (dec != dec_q)
      cnt_nxt = '0;
    else if (cnt != CNT_LAST)
      cnt_nxt = cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1       <= '0;
      sync2       <= '0;
      dec_q       <= MODE_FREE;
      cnt         <= '0;
      target_mode <= MODE_FREE;
    end else begin
      sync1 <= mode_select;
      sync2 <= sync1;
      dec_q <= dec;
      cnt   <= cnt_nxt;
      if (cnt_nxt == CNT_LAST)
        target_mode <= dec;
    end
  end

endmodule

// File: rtl/speaker_arbiter.sv
// Glitch-free speaker ownership among free/auto/learn sources.
// Ports: clk, reset (async active-low), mode_select[2:0],
//   src_speaker[2:0], src_stop_ack[2:0] -> src_enable[2:0],
//   src_stop_req[2:0], speaker, current_mode[1:0], switching.
// Build option: SPEAKER_ARB_TIMEOUT_EN adds a stop-ack timeout.
module speaker_arbiter
  import keyboard_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int GUARD_CYCLES    = 1_000_000,
  parameter int ACK_TIMEOUT     = 5_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] mode_select,
  input  logic [2:0] src_speaker,
  input  logic [2:0] src_stop_ack,
  output logic [2:0] src_enable,
  output logic [2:0] src_stop_req,
  output logic       speaker,
  output logic [1:0] current_mode,
  output logic       switching
);

  if (DEBOUNCE_CYCLES < 1 || GUARD_CYCLES < 1 ||
      ACK_TIMEOUT < 1) begin : g_bad_param
    $error("speaker_arbiter: cycle params must be >= 1");
  end

  localparam int GW = $clog2(GUARD_CYCLES) + 1;
  localparam logic [GW-1:0] G_LAST =
    GW'(GUARD_CYCLES - 1);

  arb_state_t    state;
  arb_state_t    state_nxt;
  logic [1:0]    target_mode;
  logic [GW-1:0] guard_cnt;
  logic          ack_cur;
  logic          tmo_hit;

  mode_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk        (clk),
    .reset      (reset),
    .mode_select(mode_select),
    .target_mode(target_mode)
  );

  assign ack_cur = mode_bit(src_stop_ack, current_mode);

`ifdef SPEAKER_ARB_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [TW-1:0] T_LAST =
    TW'(ACK_TIMEOUT - 1);

  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      tmo_cnt <= '0;
    else if (state_nxt != state)
      tmo_cnt <= '0;
    else if (state == ST_STOP_REQ && tmo_cnt != '1)
      tmo_cnt <= tmo_cnt + TW'(1);
  end

  assign tmo_hit = (tmo_cnt == T_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_ACTIVE;
      current_mode <= MODE_FREE;
      guard_cnt    <= '0;
    end else begin
      state <= state_nxt;
      // Late target wins: a change made mid-switch
      // is what gets granted.
      if (state == ST_GRANT)
        current_mode <= target_mode;
      if (state_nxt != state)
        guard_cnt <= '0;
      else if (state == ST_GUARD && guard_cnt != '1)
        guard_cnt <= guard_cnt + GW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_ACTIVE:
        if (target_mode != current_mode)
          state_nxt = ST_STOP_REQ;
      ST_STOP_REQ:
        if (ack_cur || tmo_hit)
          state_nxt = ST_GUARD;
      ST_GUARD:
        if (guard_cnt == G_LAST)
          state_nxt = ST_GRANT;
      ST_GRANT:
        state_nxt = ST_ACTIVE;
      default:
        state_nxt = ST_ACTIVE;
    endcase
  end

  always_comb begin
    src_enable   = '0;
    src_stop_req = '0;
    switching    = (state != ST_ACTIVE);
    unique case (state)
      ST_ACTIVE:
        src_enable = mode_onehot(current_mode);
      ST_STOP_REQ: begin
        src_enable   = mode_onehot(current_mode);
        src_stop_req = mode_onehot(current_mode);
      end
      ST_GRANT:
        src_enable = mode_onehot(target_mode);
      default: begin
        src_enable   = '0;
        src_stop_req = '0;
      end
    endcase
  end

  // Only an ACTIVE source reaches the pin, so every
  // other state drives silence one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      speaker <= 1'b0;
    else
      speaker <= (state == ST_ACTIVE) &&
                 mode_bit(src_speaker, current_mode);
  end

endmodule

// File: tb/tb_speaker_arbiter.sv
// Self-checking bench for speaker_arbiter with small cycle parameters.
// Honors SPEAKER_ARB_TIMEOUT_EN like the design.
module tb_speaker_arbiter;

  localparam int D = 4;
  localparam int G = 8;
  localparam int T = 16;
  // switch move -> STOP_REQ: 2 sync + D debounce + 1
  localparam int LAT_SEL = D + 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] mode_select = '0;
  logic [2:0] src_speaker = '0;
  logic [2:0] src_stop_ack = '0;
  logic [2:0] src_enable;
  logic [2:0] src_stop_req;
  logic       speaker;
  logic [1:0] current_mode;
  logic       switching;

  int total = 0;
  int bad   = 0;
  logic [2:0] spk_edge;
  int ref_mode = 0;
  logic [2:0] ref_oh;

  speaker_arbiter #(
    .DEBOUNCE_CYCLES(D),
    .GUARD_CYCLES   (G),
    .ACK_TIMEOUT    (T)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mode_select (mode_select),
    .src_speaker (src_speaker),
    .src_stop_ack(src_stop_ack),
    .src_enable  (src_enable),
    .src_stop_req(src_stop_req),
    .speaker     (speaker),
    .current_mode(current_mode),
    .switching   (switching)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    spk_edge = src_speaker;
    #1;
    src_speaker = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_switch(output int n);
    n = 0;
    while (switching !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    mode_select = 3'd0;
    src_stop_ack = 3'd0;
    #23;
    total++;
    if ({src_enable, src_stop_req, current_mode,
         speaker, switching} !== 10'b001_000_00_0_0) begin
      bad++;
      $display("FAIL reset_outputs got=%b%b%b%b%b exp=0010000000",
               src_enable, src_stop_req, current_mode,
               speaker, switching);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    ref_mode = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (speaker !== spk_edge[ref_mode] ||
          src_enable !== 3'b001) begin
        bad++;
        $display("FAIL reset_track spk=%b exp=%b en=%b exp=001",
                 speaker, spk_edge[ref_mode], src_enable);
      end
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 10; i++) begin
      mode_select = (i % 2 == 0) ? 3'd2 : 3'd0;
      for (int k = 0; k < 2; k++) begin
        tick();
        total++;
        if (switching !== 1'b0 || src_enable !== 3'b001) begin
          bad++;
          $display("FAIL bounce sw=%b exp=0 en=%b exp=001",
                   switching, src_enable);
        end
      end
    end
    mode_select = 3'd0;
    for (int i = 0; i < 12; i++) begin
      tick();
      total++;
      if (switching !== 1'b0 ||
          speaker !== spk_edge[ref_mode]) begin
        bad++;
        $display("FAIL bounce_settle sw=%b spk=%b exp=%b",
                 switching, speaker, spk_edge[ref_mode]);
      end
    end
  endtask

  task automatic test_change_during_guard();
    int n;
    src_stop_ack = 3'b001;
    mode_select = 3'd2;
    wait_switch(n);
    total++;
    if (n != LAT_SEL || src_stop_req !== 3'b001) begin
      bad++;
      $display("FAIL cdg_stopreq lat=%0d exp=%0d req=%b exp=001",
               n, LAT_SEL, src_stop_req);
    end
    tick();
    total++;
    if (src_enable !== 3'b000 || src_stop_req !== 3'b000 ||
        switching !== 1'b1) begin
      bad++;
      $display("FAIL cdg_ack_on_entry en=%b req=%b sw=%b exp=000/000/1",
               src_enable, src_stop_req, switching);
    end
    src_stop_ack = 3'b000;
    mode_select = 3'd0;
    for (int i = 1; i < G; i++) begin
      tick();
      total++;
      if (src_enable !== 3'b000 || speaker !== 1'b0) begin
        bad++;
        $display("FAIL cdg_guard en=%b spk=%b exp=000/0",
                 src_enable, speaker);
      end
    end
    tick();
    total++;
    if (src_enable !== 3'b001 || switching !== 1'b1) begin
      bad++;
      $display("FAIL cdg_grant en=%b sw=%b exp=001/1",
               src_enable, switching);
    end
    tick();
    ref_mode = 0;
    total++;
    if (current_mode !== 2'(ref_mode) ||
        src_enable !== 3'b001 || switching !== 1'b0) begin
      bad++;
      $display("FAIL cdg_active mode=%0d en=%b sw=%b exp=0/001/0",
               current_mode, src_enable, switching);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (switching !== 1'b0 ||
          speaker !== spk_edge[ref_mode]) begin
        bad++;
        $display("FAIL cdg_track sw=%b spk=%b exp=%b",
                 switching, speaker, spk_edge[ref_mode]);
      end
    end
  endtask

  task automatic test_switch_auto();
    int n;
    src_stop_ack = 3'b000;
    mode_select = 3'd1;
    wait_switch(n);
    total++;
    if (n != LAT_SEL) begin
      bad++;
      $display("FAIL auto_latency got=%0d exp=%0d", n, LAT_SEL);
    end
    for (int s = 0; s < 3; s++) begin
      if (s > 0) tick();
      total++;
      if (src_stop_req !== 3'b001 || src_enable !== 3'b001 ||
          (s > 0 && speaker !== 1'b0)) begin
        bad++;
        $display("FAIL auto_stopreq s=%0d req=%b en=%b spk=%b",
                 s, src_stop_req, src_enable, speaker);
      end
    end
    src_stop_ack = 3'b001;
    for (int i = 0; i < G; i++) begin
      tick();
      src_stop_ack = 3'b000;
      total++;
      if (src_enable !== 3'b000 || src_stop_req !== 3'b000 ||
          speaker !== 1'b0) begin
        bad++;
        $display("FAIL auto_guard i=%0d en=%b req=%b spk=%b",
                 i, src_enable, src_stop_req, speaker);
      end
    end
    ref_mode = 1;
    ref_oh = 3'b010;
    tick();
    total++;
    if (src_enable !== ref_oh || switching !== 1'b1) begin
      bad++;
      $display("FAIL auto_grant en=%b exp=%b sw=%b",
               src_enable, ref_oh, switching);
    end
    tick();
    total++;
    if (current_mode !== 2'(ref_mode) || src_enable !== ref_oh ||
        switching !== 1'b0 || speaker !== 1'b0) begin
      bad++;
      $display("FAIL auto_active mode=%0d en=%b sw=%b spk=%b",
               current_mode, src_enable, switching, speaker);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (speaker !== spk_edge[ref_mode]) begin
        bad++;
        $display("FAIL auto_track spk=%b exp=%b",
                 speaker, spk_edge[ref_mode]);
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    src_stop_ack = 3'b000;
    mode_select = 3'd0;
    wait_switch(n);
    total++;
    if (n != LAT_SEL || src_stop_req !== 3'b010) begin
      bad++;
      $display("FAIL tmo_stopreq lat=%0d exp=%0d req=%b exp=010",
               n, LAT_SEL, src_stop_req);
    end
`ifdef SPEAKER_ARB_TIMEOUT_EN
    for (int i = 1; i < T; i++) begin
      tick();
      total++;
      if (src_stop_req !== 3'b010 || speaker !== 1'b0) begin
        bad++;
        $display("FAIL tmo_wait i=%0d req=%b spk=%b exp=010/0",
                 i, src_stop_req, speaker);
      end
    end
    tick();
    total++;
    if (src_enable !== 3'b000 || src_stop_req !== 3'b000) begin
      bad++;
      $display("FAIL tmo_expire en=%b req=%b exp=000/000",
               src_enable, src_stop_req);
    end
`else
    for (int i = 0; i < 120; i++) begin
      tick();
      total++;
      if (src_stop_req !== 3'b010 || src_enable !== 3'b010 ||
          switching !== 1'b1 || speaker !== 1'b0) begin
        bad++;
        $display("FAIL tmo_hold i=%0d req=%b en=%b sw=%b spk=%b",
                 i, src_stop_req, src_enable, switching, speaker);
      end
    end
    src_stop_ack = 3'b010;
    tick();
    src_stop_ack = 3'b000;
    total++;
    if (src_enable !== 3'b000 || src_stop_req !== 3'b000) begin
      bad++;
      $display("FAIL tmo_late_ack en=%b req=%b exp=000/000",
               src_enable, src_stop_req);
    end
`endif
  endtask

  task automatic test_async_reset();
    repeat (3) tick();
    total++;
    if (src_enable !== 3'b000 || switching !== 1'b1) begin
      bad++;
      $display("FAIL arst_pre en=%b sw=%b exp=000/1",
               src_enable, switching);
    end
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({src_enable, src_stop_req, current_mode,
         speaker, switching} !== 10'b001_000_00_0_0) begin
      bad++;
      $display("FAIL arst_outputs got=%b%b%b%b%b exp=0010000000",
               src_enable, src_stop_req, current_mode,
               speaker, switching);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    ref_mode = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (src_enable !== 3'b001 || switching !== 1'b0 ||
          speaker !== spk_edge[ref_mode]) begin
        bad++;
        $display("FAIL arst_after en=%b sw=%b spk=%b exp=%b",
                 src_enable, switching, speaker,
                 spk_edge[ref_mode]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_change_during_guard();
    test_switch_auto();
    test_timeout();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
